// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the post-commit store buffer.
package store_buffer_pkg;

   localparam int PIPE_WIDTH    = 2;
   localparam int CPU_ADDR_BITS = 32;
   localparam int CPU_DATA_BITS = 32;
   localparam int SB_ENTRIES    = 8;
   localparam int SB_PTR_WIDTH  = $clog2(SB_ENTRIES) + 1;

   typedef struct packed {
      logic [CPU_ADDR_BITS-1:0] addr;
      logic [CPU_DATA_BITS-1:0] data;
      logic [3:0]               mask;
   } sb_entry_t;

   typedef enum logic [1:0] {
      SB_IDLE,
      SB_REQ,
      SB_WAIT
   } sb_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of commit-side, memory-side, load-check and status signals of the store buffer.
interface store_buffer_if #(
   parameter int SB_ENTRIES = store_buffer_pkg::SB_ENTRIES
) ();
   import store_buffer_pkg::*;

   localparam int CNT_W = $clog2(SB_ENTRIES) + 1;

   logic [PIPE_WIDTH-1:0]                 sb_alloc_val;
   sb_entry_t [PIPE_WIDTH-1:0]            sb_alloc_entry;
   logic [PIPE_WIDTH-1:0]                 sb_rdy;

   // dmem_req transfers on a cycle with dmem_req_val && dmem_req_rdy; while
   // valid is high without ready, dmem_req stays stable. dmem_ack later pulses
   // once to complete that single outstanding write.
   logic                                  dmem_req_val;
   sb_entry_t                             dmem_req;
   logic                                  dmem_req_rdy;
   logic                                  dmem_ack;

   logic                                  ld_chk_val;
   logic [CPU_ADDR_BITS-1:0]              ld_chk_addr;
   logic [3:0]                            ld_chk_mask;
   logic                                  ld_chk_hit;

   logic [CNT_W-1:0]                      sb_count;
   logic                                  sb_empty;
   logic                                  sb_overflow;
   sb_state_t                             sb_state;

   modport slave (
      input  sb_alloc_val, sb_alloc_entry, dmem_req_rdy, dmem_ack,
             ld_chk_val, ld_chk_addr, ld_chk_mask,
      output sb_rdy, dmem_req_val, dmem_req, ld_chk_hit,
             sb_count, sb_empty, sb_overflow, sb_state
   );

   modport master (
      output sb_alloc_val, sb_alloc_entry, dmem_req_rdy, dmem_ack,
             ld_chk_val, ld_chk_addr, ld_chk_mask,
      input  sb_rdy, dmem_req_val, dmem_req, ld_chk_hit,
             sb_count, sb_empty, sb_overflow, sb_state
   );

endinterface

// File: rtl/sb_ld_check.sv
// Overlap comparator array: flags a load whose word address and byte mask touch any valid entry.
module sb_ld_check
   import store_buffer_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]                      valid_i,
   input  logic [N-1:0][CPU_ADDR_BITS-3:0]   word_i,
   input  logic [N-1:0][3:0]                 mask_i,
   input  logic                              chk_val_i,
   input  logic [CPU_ADDR_BITS-3:0]          chk_word_i,
   input  logic [3:0]                        chk_mask_i,
   output logic                              hit_o
);

   logic [N-1:0] match;

   always_comb begin
      match = '0;
      for (int i = 0; i < N; i++) begin
         match[i] = valid_i[i] && (word_i[i] == chk_word_i) && (|(mask_i[i] & chk_mask_i));
      end
   end

   assign hit_o = chk_val_i && (|match);

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order circular queue of committed stores drained one at a time to dmem.
module store_buffer #(
   parameter int SB_ENTRIES = store_buffer_pkg::SB_ENTRIES
) (
   input logic           clk,
   input logic           rst,
   store_buffer_if.slave sb
);
   import store_buffer_pkg::*;

   localparam int IDX_W = $clog2(SB_ENTRIES);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]                      head_q, head_d, tail_q, tail_d;
   logic [PTR_W-1:0]                      count, count_post, free_cnt, n_acc;
   logic [SB_ENTRIES-1:0]                 valid_q, valid_d;
   sb_entry_t [SB_ENTRIES-1:0]            entries_q;
   sb_state_t                             state_q, state_d;
   logic                                  overflow_q, overflow_d;
   logic                                  pop;
   logic [PIPE_WIDTH-1:0]                 slot_acc;
   logic [PIPE_WIDTH-1:0][IDX_W-1:0]      slot_idx;
   logic [SB_ENTRIES-1:0][CPU_ADDR_BITS-3:0] ent_word;
   logic [SB_ENTRIES-1:0][3:0]            ent_mask;
   logic                                  unused_addr_lsb;

   assign count      = tail_q - head_q;
   assign free_cnt   = PTR_W'(SB_ENTRIES) - count;
   assign count_post = tail_d - head_q - PTR_W'(1);

   // Valid slots pack onto consecutive free entries; credit comes only from registered pointers.
   always_comb begin
      n_acc      = '0;
      overflow_d = overflow_q;
      slot_acc   = '0;
      slot_idx   = '0;
      for (int i = 0; i < PIPE_WIDTH; i++) begin
         slot_idx[i] = tail_q[IDX_W-1:0] + n_acc[IDX_W-1:0];
         if (sb.sb_alloc_val[i]) begin
            if (n_acc < free_cnt) begin
               slot_acc[i] = 1'b1;
               n_acc       = n_acc + PTR_W'(1);
            end else begin
               overflow_d = 1'b1;
            end
         end
      end
      tail_d = tail_q + n_acc;
   end

   always_comb begin
      state_d         = state_q;
      pop             = 1'b0;
      sb.dmem_req_val = 1'b0;
      case (state_q)
         SB_IDLE: begin
            if (count != '0) state_d = SB_REQ;
         end
         SB_REQ: begin
            sb.dmem_req_val = 1'b1;
            if (sb.dmem_req_rdy) state_d = SB_WAIT;
         end
         SB_WAIT: begin
            if (sb.dmem_ack) begin
               pop     = 1'b1;
               state_d = (count_post != '0) ? SB_REQ : SB_IDLE;
            end
         end
         default: state_d = SB_IDLE;
      endcase
   end

   always_comb begin
      head_d  = pop ? head_q + PTR_W'(1) : head_q;
      valid_d = valid_q;
      if (pop) valid_d[head_q[IDX_W-1:0]] = 1'b0;
      for (int i = 0; i < PIPE_WIDTH; i++) begin
         if (slot_acc[i]) valid_d[slot_idx[i]] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         valid_q    <= '0;
         state_q    <= SB_IDLE;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         valid_q    <= valid_d;
         state_q    <= state_d;
         overflow_q <= overflow_d;
      end
   end

   // Payload needs no reset: an entry is only observed while its valid bit is set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < PIPE_WIDTH; i++) begin
         if (slot_acc[i]) entries_q[slot_idx[i]] <= sb.sb_alloc_entry[i];
      end
   end

   always_comb begin
      for (int e = 0; e < SB_ENTRIES; e++) begin
         ent_word[e] = entries_q[e].addr[CPU_ADDR_BITS-1:2];
         ent_mask[e] = entries_q[e].mask;
      end
   end

   assign unused_addr_lsb = ^sb.ld_chk_addr[1:0];

   sb_ld_check #(
      .N (SB_ENTRIES)
   ) u_ld_check (
      .valid_i    (valid_q),
      .word_i     (ent_word),
      .mask_i     (ent_mask),
      .chk_val_i  (sb.ld_chk_val),
      .chk_word_i (sb.ld_chk_addr[CPU_ADDR_BITS-1:2]),
      .chk_mask_i (sb.ld_chk_mask),
      .hit_o      (sb.ld_chk_hit)
   );

   for (genvar g = 0; g < PIPE_WIDTH; g++) begin : g_rdy
      assign sb.sb_rdy[g] = (free_cnt > PTR_W'(g));
   end

   assign sb.dmem_req    = entries_q[head_q[IDX_W-1:0]];
   assign sb.sb_count    = count;
   assign sb.sb_empty    = (count == '0);
   assign sb.sb_overflow = overflow_q;
   assign sb.sb_state    = state_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: hand-computed checks plus an in-order drain scoreboard.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int EW = $bits(sb_entry_t);

   logic clk      = 1'b0;
   logic rst      = 1'b0;
   logic rdy_drv  = 1'b0;
   logic auto_ack = 1'b0;
   logic man_ack  = 1'b0;
   int   n_chk    = 0;
   int   n_bad    = 0;
   logic [EW-1:0] exp_q[$];

   store_buffer_if sb_bus ();

   store_buffer dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_bus)
   );

   always #5 clk = ~clk;

   assign sb_bus.dmem_req_rdy = rdy_drv;
   assign sb_bus.dmem_ack     = man_ack | (auto_ack & (sb_bus.sb_state == SB_WAIT));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic sb_entry_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      sb_entry_t e;
      e.addr = a;
      e.data = d;
      e.mask = m;
      return e;
   endfunction

   task automatic enq(input logic [1:0] v, input sb_entry_t e0, input sb_entry_t e1, input bit push);
      sb_bus.sb_alloc_val      = v;
      sb_bus.sb_alloc_entry[0] = e0;
      sb_bus.sb_alloc_entry[1] = e1;
      if (push) begin
         if (v[0]) exp_q.push_back(e0);
         if (v[1]) exp_q.push_back(e1);
      end
      tick();
      sb_bus.sb_alloc_val = '0;
   endtask

   task automatic wait_empty(input string tag, input int budget);
      for (int i = 0; i < budget && !sb_bus.sb_empty; i++) tick();
      chk(tag, sb_bus.sb_empty, 1'b1);
   endtask

   // Every accepted dmem request must match the oldest expected store.
   always @(negedge clk) begin
      if (rst && sb_bus.dmem_req_val && sb_bus.dmem_req_rdy) begin
         chk("drain_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) chk("drain_payload", sb_bus.dmem_req, exp_q.pop_front());
      end
   end

   initial begin
      sb_entry_t z;
      z = mk(32'h0, 32'h0, 4'h0);
      sb_bus.sb_alloc_val      = '0;
      sb_bus.sb_alloc_entry[0] = z;
      sb_bus.sb_alloc_entry[1] = z;
      sb_bus.ld_chk_val        = 1'b1;
      sb_bus.ld_chk_addr       = 32'h100;
      sb_bus.ld_chk_mask       = 4'hF;

      // reset state
      tick();
      tick();
      chk("rst_req_val", sb_bus.dmem_req_val, 1'b0);
      chk("rst_count", sb_bus.sb_count, 4'd0);
      chk("rst_empty", sb_bus.sb_empty, 1'b1);
      chk("rst_rdy", sb_bus.sb_rdy, 2'b11);
      chk("rst_ovf", sb_bus.sb_overflow, 1'b0);
      chk("rst_hit", sb_bus.ld_chk_hit, 1'b0);
      chk("rst_state", sb_bus.sb_state, SB_IDLE);
      sb_bus.ld_chk_val = 1'b0;
      rst = 1'b1;
      tick();

      // two stores, memory always ready and acking
      rdy_drv  = 1'b1;
      auto_ack = 1'b1;
      enq(2'b11, mk(32'h100, 32'hAAAA_0001, 4'hF), mk(32'h104, 32'h0000_BB00, 4'h2), 1'b1);
      chk("t1_count_n1", sb_bus.sb_count, 4'd2);
      chk("t1_val_n1", sb_bus.dmem_req_val, 1'b0);
      tick();
      chk("t1_val_n2", sb_bus.dmem_req_val, 1'b1);
      chk("t1_addr_n2", sb_bus.dmem_req.addr, 32'h100);
      tick();
      chk("t1_wait", sb_bus.sb_state, SB_WAIT);
      tick();
      chk("t1_count_pop1", sb_bus.sb_count, 4'd1);
      chk("t1_addr_2nd", sb_bus.dmem_req.addr, 32'h104);
      tick();
      tick();
      chk("t1_empty", sb_bus.sb_empty, 1'b1);
      chk("t1_idle", sb_bus.sb_state, SB_IDLE);

      // fill to full while memory stalls, then drain
      rdy_drv = 1'b0;
      for (int k = 0; k < 3; k++)
         enq(2'b11, mk(32'h300 + 32'(8 * k), 32'hC0DE_0000 + 32'(2 * k), 4'hF),
             mk(32'h304 + 32'(8 * k), 32'hC0DE_0001 + 32'(2 * k), 4'hF), 1'b1);
      chk("t2_count6", sb_bus.sb_count, 4'd6);
      chk("t2_rdy6", sb_bus.sb_rdy, 2'b11);
      enq(2'b01, mk(32'h318, 32'hC0DE_0006, 4'h1), z, 1'b1);
      chk("t2_count7", sb_bus.sb_count, 4'd7);
      chk("t2_rdy7", sb_bus.sb_rdy, 2'b01);
      enq(2'b01, mk(32'h31C, 32'hC0DE_0007, 4'h8), z, 1'b1);
      chk("t2_count8", sb_bus.sb_count, 4'd8);
      chk("t2_rdy8", sb_bus.sb_rdy, 2'b00);
      chk("t2_held_val", sb_bus.dmem_req_val, 1'b1);
      chk("t2_held_addr", sb_bus.dmem_req.addr, 32'h300);
      rdy_drv = 1'b1;
      wait_empty("t2_drained", 40);
      chk("t2_rdy_after", sb_bus.sb_rdy, 2'b11);
      enq(2'b11, mk(32'h340, 32'h1111_0000, 4'hF), mk(32'h344, 32'h2222_0000, 4'hF), 1'b1);
      enq(2'b01, mk(32'h348, 32'h3333_0000, 4'hF), z, 1'b1);
      wait_empty("t2_wrap_drained", 20);

      // load check, including same-cycle invisibility and hold through WAIT
      rdy_drv  = 1'b0;
      auto_ack = 1'b0;
      sb_bus.sb_alloc_val      = 2'b01;
      sb_bus.sb_alloc_entry[0] = mk(32'h200, 32'h5555_5555, 4'h3);
      exp_q.push_back(mk(32'h200, 32'h5555_5555, 4'h3));
      sb_bus.ld_chk_val  = 1'b1;
      sb_bus.ld_chk_addr = 32'h200;
      sb_bus.ld_chk_mask = 4'h1;
      #1;
      chk("t4_same_cycle", sb_bus.ld_chk_hit, 1'b0);
      tick();
      sb_bus.sb_alloc_val = '0;
      #1;
      chk("t4_hit_m1", sb_bus.ld_chk_hit, 1'b1);
      sb_bus.ld_chk_mask = 4'hC;
      #1;
      chk("t4_miss_mC", sb_bus.ld_chk_hit, 1'b0);
      sb_bus.ld_chk_addr = 32'h203;
      sb_bus.ld_chk_mask = 4'h1;
      #1;
      chk("t4_hit_lsb", sb_bus.ld_chk_hit, 1'b1);
      sb_bus.ld_chk_addr = 32'h204;
      #1;
      chk("t4_miss_word", sb_bus.ld_chk_hit, 1'b0);
      sb_bus.ld_chk_addr = 32'h200;
      sb_bus.ld_chk_val  = 1'b0;
      #1;
      chk("t4_no_val", sb_bus.ld_chk_hit, 1'b0);
      sb_bus.ld_chk_val = 1'b1;
      tick();
      rdy_drv = 1'b1;
      tick();
      rdy_drv = 1'b0;
      chk("t4_in_wait", sb_bus.sb_state, SB_WAIT);
      chk("t4_hit_wait", sb_bus.ld_chk_hit, 1'b1);
      tick();
      chk("t4_hit_wait2", sb_bus.ld_chk_hit, 1'b1);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("t4_hit_after_ack", sb_bus.ld_chk_hit, 1'b0);
      chk("t4_empty", sb_bus.sb_empty, 1'b1);
      sb_bus.ld_chk_val = 1'b0;

      // enqueue alongside a pop at count 7, then overflow at full
      enq(2'b11, mk(32'h400, 32'h4000_0000, 4'hF), mk(32'h404, 32'h4000_0001, 4'hF), 1'b1);
      enq(2'b11, mk(32'h408, 32'h4000_0002, 4'hF), mk(32'h40C, 32'h4000_0003, 4'hF), 1'b1);
      enq(2'b11, mk(32'h410, 32'h4000_0004, 4'hF), mk(32'h414, 32'h4000_0005, 4'hF), 1'b1);
      enq(2'b01, mk(32'h418, 32'h4000_0006, 4'hF), z, 1'b1);
      rdy_drv = 1'b1;
      tick();
      rdy_drv = 1'b0;
      chk("t5_wait7", sb_bus.sb_count, 4'd7);
      man_ack = 1'b1;
      enq(2'b01, mk(32'h41C, 32'h4000_0007, 4'hF), z, 1'b1);
      man_ack = 1'b0;
      chk("t5_enq_pop", sb_bus.sb_count, 4'd7);
      chk("t5_ovf_clear", sb_bus.sb_overflow, 1'b0);
      enq(2'b01, mk(32'h420, 32'h4000_0008, 4'hF), z, 1'b1);
      chk("t5_full", sb_bus.sb_count, 4'd8);
      enq(2'b11, mk(32'h424, 32'hDEAD_0000, 4'hF), mk(32'h428, 32'hDEAD_0001, 4'hF), 1'b0);
      chk("t5_ovf_set", sb_bus.sb_overflow, 1'b1);
      chk("t5_dropped", sb_bus.sb_count, 4'd8);
      rdy_drv  = 1'b1;
      auto_ack = 1'b1;
      wait_empty("t5_drained", 40);
      chk("t5_ovf_sticky", sb_bus.sb_overflow, 1'b1);

      // reset while a request is outstanding
      rdy_drv  = 1'b0;
      auto_ack = 1'b0;
      enq(2'b11, mk(32'h500, 32'h5000_0000, 4'hF), mk(32'h504, 32'h5000_0001, 4'hF), 1'b1);
      enq(2'b01, mk(32'h508, 32'h5000_0002, 4'hF), z, 1'b1);
      rdy_drv = 1'b1;
      tick();
      rdy_drv = 1'b0;
      chk("t6_in_wait", sb_bus.sb_state, SB_WAIT);
      sb_bus.ld_chk_val  = 1'b1;
      sb_bus.ld_chk_addr = 32'h504;
      sb_bus.ld_chk_mask = 4'hF;
      rst = 1'b0;
      #1;
      chk("t6_req_val", sb_bus.dmem_req_val, 1'b0);
      chk("t6_count", sb_bus.sb_count, 4'd0);
      chk("t6_empty", sb_bus.sb_empty, 1'b1);
      chk("t6_ovf", sb_bus.sb_overflow, 1'b0);
      chk("t6_rdy", sb_bus.sb_rdy, 2'b11);
      chk("t6_hit", sb_bus.ld_chk_hit, 1'b0);
      chk("t6_state", sb_bus.sb_state, SB_IDLE);
      exp_q.delete();
      sb_bus.ld_chk_val = 1'b0;
      tick();
      rst      = 1'b1;
      rdy_drv  = 1'b1;
      auto_ack = 1'b1;

      // sparse slot pattern into an empty, freshly reset queue
      enq(2'b10, mk(32'hBAD0, 32'hBAD0_BAD0, 4'hF), mk(32'h700, 32'h7777_0000, 4'h4), 1'b1);
      chk("t3_sparse_count", sb_bus.sb_count, 4'd1);
      wait_empty("t3_drained", 10);

      enq(2'b11, mk(32'h600, 32'h6000_0000, 4'hF), mk(32'h604, 32'h6000_0001, 4'hF), 1'b1);
      chk("t6_accept2", sb_bus.sb_count, 4'd2);
      wait_empty("t6_drained", 20);

      tick();
      chk("sb_leftover", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
